sys_reg_file: RTL

Configuration/operand register file sitting directly downstream of the system controller. It accepts the controller's one-port write and read strobes (Address, WrEn, RdEn, WrData) and returns registered read data with a valid pulse. It exports the four low registers to the ALU (operands A/B), the UART (parity/prescale) and the clock divider (ratio), and pulses a change flag when a configuration register actually changes value.

---
 rtl/sys_reg_file.sv | 99 +++++++++
 1 files changed

// File: rtl/sys_reg_file.sv
// sys_reg_file: DEPTH x WIDTH flop register file behind the system controller,
// exporting REG0..REG3 and pulsing Cfg_Update on real REG2/REG3 changes.
// Optional: define REGFILE_RW_FORWARD_EN to service same-cycle write+read.
module sys_reg_file #(
  parameter int unsigned    WIDTH    = 8,
  parameter int unsigned    DEPTH    = 16,
  parameter logic [WIDTH-1:0] REG2_RST = 8'b1000_0001,
  parameter logic [WIDTH-1:0] REG3_RST = 8'd32
) (
  input  logic                     CLK_IN,
  input  logic                     RST_IN,
  input  logic [$clog2(DEPTH)-1:0] Address,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic [WIDTH-1:0]         WrData,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_Valid,
  output logic [WIDTH-1:0]         REG0,
  output logic [WIDTH-1:0]         REG1,
  output logic [WIDTH-1:0]         REG2,
  output logic [WIDTH-1:0]         REG3,
  output logic                     Cfg_Update
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             cfg_update_q, cfg_update_d;
  logic             rd_accept;
  logic             cfg_addr;

  function automatic logic [WIDTH-1:0] rst_val(input int unsigned idx);
    if (idx == 2)      return REG2_RST;
    else if (idx == 3) return REG3_RST;
    else               return '0;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (WrEn) begin
      mem_d[Address] = WrData;
    end
  end

`ifdef REGFILE_RW_FORWARD_EN
  // Single address port: a colliding read always targets the word being written.
  always_comb begin
    rd_accept = RdEn;
    rd_data_d = rd_data_q;
    if (RdEn) begin
      rd_data_d = WrEn ? WrData : mem_q[Address];
    end
  end
`else
  always_comb begin
    rd_accept = RdEn & ~WrEn;
    rd_data_d = rd_data_q;
    if (rd_accept) begin
      rd_data_d = mem_q[Address];
    end
  end
`endif

  assign rd_valid_d   = rd_accept;
  assign cfg_addr     = (Address == AW'(2)) || (Address == AW'(3));
  assign cfg_update_d = WrEn && cfg_addr && (WrData != mem_q[Address]);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= rst_val(i);
      end
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      cfg_update_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  assign RdData       = rd_data_q;
  assign RdData_Valid = rd_valid_q;
  assign Cfg_Update   = cfg_update_q;
  assign REG0         = mem_q[0];
  assign REG1         = mem_q[1];
  assign REG2         = mem_q[2];
  assign REG3         = mem_q[3];

endmodule
